// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DW2       = 2 * DIV_WIDTH;
  localparam int unsigned CNT_W     = $clog2(DW2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Magnitude of a two's-complement dividend; -2^(DW2-1) maps to 2^(DW2-1) unsigned.
  function automatic logic [DW2-1:0] abs_val(input logic [DW2-1:0] x);
    return x[DW2-1] ? ((~x) + DW2'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One radix-2 restoring iteration: shift {r,q} left, subtract divisor when it fits.
module divider_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0]   r_in,
  input  logic [2*WIDTH-1:0] q_in,
  input  logic [WIDTH:0]     d,
  output logic [WIDTH-1:0]   r_out,
  output logic [2*WIDTH-1:0] q_out
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned QW = 2 * WIDTH;

  logic [RW-1:0] r_sh;
  logic [RW-1:0] diff;

  always_comb begin
    r_sh  = {r_in, q_in[QW-1]};
    diff  = r_sh - d;
    q_out = {q_in[QW-2:0], 1'b0};
    r_out = WIDTH'(r_sh);
    if (r_sh >= d) begin
      r_out    = WIDTH'(diff);
      q_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider (2W / W -> 2W quotient, W remainder).
// Optional early exit for |dividend| < |divisor| under SEQ_DIVIDER_EARLY_EXIT_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int unsigned QW = 2 * WIDTH;
  localparam int unsigned RW = WIDTH + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [QW-1:0]      q_q, q_d;
  logic [RW-1:0]      d_q, d_d;
  logic               sign_quo_q, sign_quo_d;
  logic               sign_rem_q, sign_rem_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [QW-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               overflow_q, overflow_d;

  logic [QW-1:0]      dd_abs;
  logic [RW-1:0]      dv_ext, dv_abs;
  logic               ovf_det, early;
  logic [WIDTH-1:0]   step_r_in, step_r;
  logic [QW-1:0]      step_q_in, step_q;
  logic [RW-1:0]      step_d;

  // Operand magnitudes; divisor extended one bit so 2^(W-1) is representable.
  always_comb begin
    dd_abs  = abs_val(dividend);
    dv_ext  = {divisor[WIDTH-1], divisor};
    dv_abs  = dv_ext[RW-1] ? ((~dv_ext) + RW'(1)) : dv_ext;
    ovf_det = (dividend == {1'b1, {(QW-1){1'b0}}}) && (divisor == {WIDTH{1'b1}});
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    early   = (dd_abs < QW'(dv_abs));
`else
    early   = 1'b0;
`endif
  end

  // The first iteration runs on the incoming operands during accept.
  always_comb begin
    if (state_q == IDLE) begin
      step_r_in = '0;
      step_q_in = dd_abs;
      step_d    = dv_abs;
    end else begin
      step_r_in = r_q;
      step_q_in = q_q;
      step_d    = d_q;
    end
  end

  divider_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (step_r_in),
    .q_in  (step_q_in),
    .d     (step_d),
    .r_out (step_r),
    .q_out (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    sign_quo_d  = sign_quo_q;
    sign_rem_d  = sign_rem_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_quo_d = dividend[QW-1] ^ divisor[WIDTH-1];
          sign_rem_d = dividend[QW-1];
          ovf_d      = ovf_det;
          d_d        = dv_abs;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend[WIDTH-1:0];
            dbz_d       = 1'b1;
            overflow_d  = 1'b0;
            out_valid_d = 1'b1;
          end else if (early) begin
            state_d     = DONE;
            quotient_d  = '0;
            remainder_d = dividend[WIDTH-1:0];
            dbz_d       = 1'b0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = step_r;
            q_d     = step_q;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(QW - 1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = sign_quo_q ? ((~q_q) + QW'(1)) : q_q;
        remainder_d = sign_rem_q ? ((~r_q) + WIDTH'(1)) : r_q;
        dbz_d       = 1'b0;
        overflow_d  = ovf_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      sign_quo_q  <= sign_quo_d;
      sign_rem_q  <= sign_rem_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues expectations, monitor checks handoffs.
module tb_seq_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    logic [31:0] lat;
  } exp_t;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  localparam int unsigned SMALL_LAT = 1;
`else
  localparam int unsigned SMALL_LAT = 33;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  logic ov_prev = 1'b0;
  exp_t sb[$];
  exp_t head;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [15:0] r,
                              input logic dbz, input logic ovf, input int unsigned lat);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.ovf = ovf;
    e.lat = 32'(lat);
    return e;
  endfunction

  // Monitor: latency on the rising edge of out_valid, contents every valid cycle, pop on handoff.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
        n_acc++;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'(0));
        end else begin
          head = sb[0];
          if (!ov_prev) chk("latency", 32'(cyc - acc_cyc), head.lat);
          chk("quotient", quotient, head.q);
          chk("remainder", 32'(remainder), 32'(head.r));
          chk("div_by_zero", 32'(div_by_zero), 32'(head.dbz));
          chk("overflow", 32'(overflow), 32'(head.ovf));
          if (out_ready) begin
            void'(sb.pop_front());
            n_pop++;
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [31:0] dd, input logic [15:0] dv, input logic push,
                       input exp_t e, input logic keep);
    int start;
    start = n_acc;
    if (push) sb.push_back(e);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && n_acc == start; i++) @(negedge clk);
    if (n_acc == start) chk("accept_timeout", 32'(n_acc), 32'(start + 1));
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_result(input int target);
    for (int i = 0; i < 200 && n_pop < target; i++) @(posedge clk);
    if (n_pop < target) chk("result_timeout", 32'(n_pop), 32'(target));
    #1;
  endtask

  task automatic run(input logic [31:0] dd, input logic [15:0] dv, input exp_t e);
    int p;
    p = n_pop;
    issue(dd, dv, 1'b1, e, 1'b0);
    wait_result(p + 1);
  endtask

  initial begin
    int a;
    int p;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_quotient", quotient, 32'h0);
    chk("rst_remainder", 32'(remainder), 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(32'd100, 16'd7, mk(32'd14, 16'd2, 1'b0, 1'b0, 33));
    run(-32'sd100, 16'd7, mk(32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0, 33));
    run(32'd100, -16'sd7, mk(32'hFFFF_FFF2, 16'd2, 1'b0, 1'b0, 33));
    run(-32'sd100, -16'sd7, mk(32'd14, 16'hFFFE, 1'b0, 1'b0, 33));
    run(-32'sd3962745, -16'sd321, mk(32'd12345, 16'd0, 1'b0, 1'b0, 33));
    run(32'h8000_0000, 16'hFFFF, mk(32'h8000_0000, 16'd0, 1'b0, 1'b1, 33));
    run(32'h0000_1234, 16'h0000, mk(32'hFFFF_FFFF, 16'h1234, 1'b1, 1'b0, 1));
    run(32'd70000, 16'h8000, mk(32'hFFFF_FFFE, 16'h1170, 1'b0, 1'b0, 33));
    run(32'd3, 16'd7, mk(32'd0, 16'd3, 1'b0, 1'b0, SMALL_LAT));

    // Back-pressure: hold the result while new operands wait at the input.
    out_ready = 1'b0;
    p = n_pop;
    issue(32'd100, 16'd7, 1'b1, mk(32'd14, 16'd2, 1'b0, 1'b0, 33), 1'b1);
    a = n_acc;
    dividend = 32'd5;
    divisor  = 16'd2;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'(0));
      chk("hold_out_valid", 32'(out_valid), 32'(1));
    end
    chk("hold_no_accept", 32'(n_acc), 32'(a));
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_result(p + 1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("handoff_no_accept", 32'(n_acc), 32'(a));
    chk("handoff_in_ready", 32'(in_ready), 32'(1));

    // Reset in the middle of an iteration; the partial result must vanish.
    issue(32'd100, 16'd7, 1'b0, mk(32'd0, 16'd0, 1'b0, 1'b0, 0), 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(in_ready), 32'(1));
    chk("postrst_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    run(32'd5, 16'd2, mk(32'd2, 16'd1, 1'b0, 1'b0, 33));

    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

endmodule
